// File: rtl/ntt_stage_ctrl_if.sv
// Control/address bundle between the NTT stage sequencer and the butterfly/bank logic.
interface ntt_stage_ctrl_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  start_i;
  logic                  is_ntt_i;
  logic                  busy_o;
  logic                  done_o;
  logic [7:0]            len_o;
  logic                  start_bu_o;
  logic                  is_ntt_o;
  logic [2:0]            stage_o;
  logic                  rd_en_o;
  logic [ADDR_WIDTH-1:0] rd_addr_a_o;
  logic [ADDR_WIDTH-1:0] rd_addr_b_o;
  logic                  wr_en_o;
  logic [ADDR_WIDTH-1:0] wr_addr_a_o;
  logic [ADDR_WIDTH-1:0] wr_addr_b_o;
  logic [7:0]            wr_len_o;

  modport master (
    output start_i, is_ntt_i,
    input  busy_o, done_o, len_o, start_bu_o, is_ntt_o, stage_o,
    input  rd_en_o, rd_addr_a_o, rd_addr_b_o,
    input  wr_en_o, wr_addr_a_o, wr_addr_b_o, wr_len_o
  );

  modport slave (
    input  start_i, is_ntt_i,
    output busy_o, done_o, len_o, start_bu_o, is_ntt_o, stage_o,
    output rd_en_o, rd_addr_a_o, rd_addr_b_o,
    output wr_en_o, wr_addr_a_o, wr_addr_b_o, wr_len_o
  );
endinterface

// File: rtl/ntt_stage_ctrl.sv
// Seven-stage sequencer for the 8-butterfly NTT/iNTT datapath: bank read
// addressing, delayed write-back addressing and inter-stage pipeline drain.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start_i; mode latched on acceptance
// S_SETUP | one cycle: start_bu_o pulse, len_o valid, row counter cleared
// S_RUN   | 16 cycles of bank reads, cnt 0..15
// S_DRAIN | PIPE_LAT cycles with no reads so write-backs land before next stage
// S_DONE  | one-cycle done_o pulse, back to idle
module ntt_stage_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int PIPE_LAT   = 5
) (
  input logic             clk_i,
  input logic             rst_i,
  ntt_stage_ctrl_if.slave bus
);

  localparam int PW = 1 + 2 * ADDR_WIDTH + 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [2:0]            r_stage;
  logic [3:0]            r_cnt;
  logic [3:0]            r_dcnt;
  logic                  r_is_ntt;
  logic                  r_busy;
  logic                  r_done;
  logic [7:0]            r_len;
  logic                  r_start_bu;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_rd_addr_a;
  logic [ADDR_WIDTH-1:0] r_rd_addr_b;
  logic [PW-1:0]         r_pipe [PIPE_LAT];

  logic [3:0]            w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_a;
  logic [ADDR_WIDTH-1:0] w_addr_b;
  logic [PW-1:0]         w_pipe_in;
  logic [PW-1:0]         w_pipe_out;

  function automatic logic [7:0] f_len(input logic [2:0] stage, input logic ntt);
    return ntt ? (8'd128 >> stage) : (8'd2 << stage);
  endfunction

  // Addresses are computed for the row the next RUN cycle will read.
  always_comb begin
    w_cnt_nxt = (r_state == S_RUN) ? r_cnt + 4'd1 : 4'd0;
    w_addr_a  = '0;
    w_addr_b  = '0;
    if (r_len >= 8'd32) begin
      w_addr_a = ADDR_WIDTH'(w_cnt_nxt);
      w_addr_b = w_addr_a + ADDR_WIDTH'(16);
    end else if (r_len == 8'd16) begin
      w_addr_a = ADDR_WIDTH'({w_cnt_nxt[3:1], 1'b0, w_cnt_nxt[0]});
      w_addr_b = w_addr_a + ADDR_WIDTH'(2);
    end else begin
      w_addr_a = ADDR_WIDTH'({w_cnt_nxt, 1'b0});
      w_addr_b = w_addr_a + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_stage     <= 3'd0;
      r_cnt       <= 4'd0;
      r_dcnt      <= 4'd0;
      r_is_ntt    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_len       <= 8'd0;
      r_start_bu  <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
    end else begin
      r_start_bu  <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_state    <= S_SETUP;
            r_is_ntt   <= bus.is_ntt_i;
            r_stage    <= 3'd0;
            r_busy     <= 1'b1;
            r_start_bu <= 1'b1;
            r_len      <= f_len(3'd0, bus.is_ntt_i);
            r_cnt      <= 4'd0;
          end
        end
        S_SETUP: begin
          r_state     <= S_RUN;
          r_cnt       <= 4'd0;
          r_rd_en     <= 1'b1;
          r_rd_addr_a <= w_addr_a;
          r_rd_addr_b <= w_addr_b;
        end
        S_RUN: begin
          if (r_cnt == 4'd15) begin
            r_state <= S_DRAIN;
            r_dcnt  <= 4'(PIPE_LAT - 1);
          end else begin
            r_cnt       <= w_cnt_nxt;
            r_rd_en     <= 1'b1;
            r_rd_addr_a <= w_addr_a;
            r_rd_addr_b <= w_addr_b;
          end
        end
        S_DRAIN: begin
          if (r_dcnt != 4'd0) begin
            r_dcnt <= r_dcnt - 4'd1;
          end else if (r_stage == 3'd6) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_len   <= 8'd0;
          end else begin
            r_state    <= S_SETUP;
            r_stage    <= r_stage + 3'd1;
            r_start_bu <= 1'b1;
            r_len      <= f_len(r_stage + 3'd1, r_is_ntt);
            r_cnt      <= 4'd0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_stage <= 3'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Idle slots carry all-zero entries, so write addresses/length are 0 whenever wr_en is 0.
  assign w_pipe_in = {r_rd_en, r_rd_addr_a, r_rd_addr_b, (r_rd_en ? r_len : 8'd0)};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < PIPE_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_pipe_in;
      for (int i = 1; i < PIPE_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_pipe_out = r_pipe[PIPE_LAT-1];

  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
  assign bus.len_o       = r_len;
  assign bus.start_bu_o  = r_start_bu;
  assign bus.is_ntt_o    = r_is_ntt;
  assign bus.stage_o     = r_stage;
  assign bus.rd_en_o     = r_rd_en;
  assign bus.rd_addr_a_o = r_rd_addr_a;
  assign bus.rd_addr_b_o = r_rd_addr_b;
  assign bus.wr_en_o     = w_pipe_out[PW-1];
  assign bus.wr_addr_a_o = w_pipe_out[PW-2 -: ADDR_WIDTH];
  assign bus.wr_addr_b_o = w_pipe_out[PW-2-ADDR_WIDTH -: ADDR_WIDTH];
  assign bus.wr_len_o    = w_pipe_out[7:0];

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Scoreboard bench for ntt_stage_ctrl: a transform-level model queues expected
// start_bu/read/write/done events; a negedge monitor pops and compares them.
module tb_ntt_stage_ctrl;

  localparam int P = 5;
  localparam int S = 17 + P;

  typedef struct packed {
    logic [31:0] t;
    logic [2:0]  stage;
    logic [7:0]  len;
    logic [4:0]  a;
    logic [4:0]  b;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_fail;

  ntt_stage_ctrl_if #(.ADDR_WIDTH(5)) bus ();
  ntt_stage_ctrl_if #(.ADDR_WIDTH(5)) bus1 ();

  ntt_stage_ctrl #(.ADDR_WIDTH(5), .PIPE_LAT(P)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  ntt_stage_ctrl #(.ADDR_WIDTH(5), .PIPE_LAT(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t q_bu[$];
  ev_t q_rd[$];
  ev_t q_wr[$];
  int  q_done[$];

  int b_lo = 0;
  int b_hi = -1;
  int idle_from = 0;
  int t_last = 0;
  bit mode_exp = 1'b0;
  int wr_n = 0;
  int done_n = 0;
  int done1_cyc = -1;
  int done1_n = 0;
  int wr1_n = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(input int t, input int s, input int ln, input int a, input int b);
    ev_t e;
    e.t = 32'(t); e.stage = 3'(s); e.len = 8'(ln); e.a = 5'(a); e.b = 5'(b);
    return e;
  endfunction

  // Whole-transform expectation from the stage/length/address rules.
  task automatic push_transform(input int t0, input bit m);
    for (int s = 0; s < 7; s++) begin
      int ln;
      ln = m ? (128 >> s) : (2 << s);
      q_bu.push_back(mk(t0 + S*s, s, ln, 0, 0));
      for (int k = 0; k < 16; k++) begin
        int a;
        int b;
        if (ln >= 32) begin a = k; b = k + 16; end
        else if (ln == 16) begin a = (k / 2) * 4 + (k % 2); b = a + 2; end
        else begin a = 2 * k; b = a + 1; end
        q_rd.push_back(mk(t0 + 1 + S*s + k, s, ln, a, b));
        q_wr.push_back(mk(t0 + 1 + S*s + k + P, 0, ln, a, b));
      end
    end
    q_done.push_back(t0 + 7*S);
  endtask

  task automatic drive(input bit s, input bit m);
    @(negedge clk);
    bus.start_i  = s;
    bus.is_ntt_i = m;
    if (s && (cyc + 1) >= idle_from) begin
      t_last    = cyc + 1;
      mode_exp  = m;
      b_lo      = t_last;
      b_hi      = t_last + 7*S - 1;
      idle_from = t_last + 7*S + 2;
      push_transform(t_last, m);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {19'd0, bus.busy_o, bus.done_o, bus.len_o, bus.start_bu_o, bus.is_ntt_o,
            bus.stage_o, bus.rd_en_o, bus.rd_addr_a_o, bus.rd_addr_b_o,
            bus.wr_en_o, bus.wr_addr_a_o, bus.wr_addr_b_o, bus.wr_len_o};
  endfunction

  always @(negedge clk) begin : mon
    ev_t act;
    bit  bexp;
    bexp = (cyc >= b_lo) && (cyc <= b_hi);
    chk("busy", 64'(bus.busy_o), 64'(bexp));
    if (bexp) chk("is_ntt_o", 64'(bus.is_ntt_o), 64'(mode_exp));
    else      chk("len_idle", 64'(bus.len_o), 64'd0);
    if (bus.start_bu_o) begin
      act = mk(cyc, int'(bus.stage_o), int'(bus.len_o), 0, 0);
      if (q_bu.size() == 0) chk("start_bu_extra", 64'(bus.start_bu_o), 64'd0);
      else chk("start_bu", 64'(act), 64'(q_bu.pop_front()));
    end
    if (bus.rd_en_o) begin
      act = mk(cyc, int'(bus.stage_o), int'(bus.len_o), int'(bus.rd_addr_a_o), int'(bus.rd_addr_b_o));
      if (q_rd.size() == 0) chk("rd_extra", 64'(bus.rd_en_o), 64'd0);
      else chk("rd_ev", 64'(act), 64'(q_rd.pop_front()));
    end
    if (bus.wr_en_o) begin
      wr_n++;
      act = mk(cyc, 0, int'(bus.wr_len_o), int'(bus.wr_addr_a_o), int'(bus.wr_addr_b_o));
      if (q_wr.size() == 0) chk("wr_extra", 64'(bus.wr_en_o), 64'd0);
      else chk("wr_ev", 64'(act), 64'(q_wr.pop_front()));
    end else begin
      chk("wr_idle", 64'({bus.wr_len_o, bus.wr_addr_a_o, bus.wr_addr_b_o}), 64'd0);
    end
    if (bus.done_o) begin
      done_n++;
      if (q_done.size() == 0) chk("done_extra", 64'(bus.done_o), 64'd0);
      else chk("done_cyc", 64'(cyc), 64'(q_done.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (bus1.wr_en_o) wr1_n++;
    if (bus1.done_o) begin
      done1_n++;
      done1_cyc = cyc;
    end
  end

  initial begin : main
    int t1;
    int tr;
    rst_n = 1'b0;
    bus.start_i = 1'b0;  bus.is_ntt_i = 1'b0;
    bus1.start_i = 1'b0; bus1.is_ntt_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;

    // Forward NTT with a PIPE_LAT=1 instance started on the same edge.
    drive(1'b1, 1'b1);
    bus1.start_i = 1'b1; bus1.is_ntt_i = 1'b1;
    t1 = cyc + 1;
    drive(1'b0, 1'b0);
    bus1.start_i = 1'b0;
    repeat (170) drive(1'b0, 1'($urandom_range(0, 1)));
    chk("p1_done_cyc", 64'(done1_cyc), 64'(t1 + 126));
    chk("p1_done_n", 64'(done1_n), 64'd1);
    chk("p1_wr_n", 64'(wr1_n), 64'd112);
    chk("p5_wr_n", 64'(wr_n), 64'd112);

    // Inverse NTT with is_ntt_i wiggling while busy.
    drive(1'b1, 1'b0);
    repeat (170) drive(1'b0, 1'($urandom_range(0, 1)));

    // start_i held high across back-to-back transforms.
    repeat (330) drive(1'b1, 1'($urandom_range(0, 1)));
    repeat (170) drive(1'b0, 1'b0);

    // Random start pulses and mode noise.
    repeat (1200) drive(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    repeat (170) drive(1'b0, 1'b0);

    // Reset in cycle 60 of a transform (stage 2 RUN).
    drive(1'b1, 1'b1);
    tr = t_last;
    repeat (59) drive(1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_rst_rd_en", 64'(bus.rd_en_o), 64'd1);
    rst_n = 1'b0;
    q_bu.delete(); q_rd.delete(); q_wr.delete(); q_done.delete();
    b_hi = -1;
    idle_from = 0;
    #1;
    chk("midrst_cyc", 64'(cyc), 64'(tr + 59));
    chk("midrst_outs", all_outs(), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_n = 0;
    done_n = 0;
    repeat (40) drive(1'b0, 1'($urandom_range(0, 1)));
    chk("post_rst_wr_n", 64'(wr_n), 64'd0);
    chk("post_rst_done_n", 64'(done_n), 64'd0);

    // Recovery transform after the reset.
    drive(1'b1, 1'b0);
    repeat (170) drive(1'b0, 1'b0);

    chk("q_bu_left", 64'(q_bu.size()), 64'd0);
    chk("q_rd_left", 64'(q_rd.size()), 64'd0);
    chk("q_wr_left", 64'(q_wr.size()), 64'd0);
    chk("q_done_left", 64'(q_done.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
